// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the time-shared fixed-point multiplier scheduler.
package mult_share_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Default operand/result format is Q6.10.
  localparam int DefAWidth   = 16;
  localparam int DefAPoint   = 10;
  localparam int DefBWidth   = 16;
  localparam int DefBPoint   = 10;
  localparam int DefOutWidth = 16;
  localparam int DefOutPoint = 10;
  localparam int DefNReq     = 3;
  localparam int DefIdWidth  = clog2_min1(DefNReq);

  typedef struct packed {
    logic                  valid;
    logic [DefIdWidth-1:0] id;
    logic [DefAWidth-1:0]  a;
    logic [DefBWidth-1:0]  b;
  } s1_stage_t;

  typedef struct packed {
    logic                   valid;
    logic [DefIdWidth-1:0]  id;
    logic [DefOutWidth-1:0] m;
  } s2_stage_t;

endpackage

// File: rtl/mult_share_sched_multiplier.sv
// Signed multiply with truncation toward -inf (arithmetic shift) and wrap on overflow.
module multiplier #(
  parameter int AWidth   = 16,
  parameter int BWidth   = 16,
  parameter int OutWidth = 16,
  parameter int Shift    = 10
) (
  input  logic signed [AWidth-1:0]   a_i,
  input  logic signed [BWidth-1:0]   b_i,
  output logic signed [OutWidth-1:0] m_o
);

  logic signed [AWidth+BWidth-1:0] p;

  assign p   = a_i * b_i;
  assign m_o = OutWidth'(p >>> Shift);

endmodule

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after the last grant.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int N = 3,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [N-1:0] grant_onehot_o,
  output logic [W-1:0] grant_idx_o,
  output logic         any_o
);

  always_comb begin
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    any_o          = 1'b0;
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = (int'(last_i) + off) % N;
      if (!any_o && req_i[idx]) begin
        any_o               = 1'b1;
        grant_idx_o         = W'(idx);
        grant_onehot_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one multiplier between NReq requesters, two-stage pipeline.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int NReq     = DefNReq,
  parameter int AWidth   = DefAWidth,
  parameter int APoint   = DefAPoint,
  parameter int BWidth   = DefBWidth,
  parameter int BPoint   = DefBPoint,
  parameter int OutWidth = DefOutWidth,
  parameter int OutPoint = DefOutPoint,
  parameter int IdWidth  = clog2_min1(NReq)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NReq-1:0]          req_valid_i,
  output logic [NReq-1:0]          req_ready_o,
  input  logic [NReq*AWidth-1:0]   req_a_i,
  input  logic [NReq*BWidth-1:0]   req_b_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [OutWidth-1:0]      res_m_o,
  output logic [IdWidth-1:0]       res_id_o,
  output logic                     busy_o
);

  localparam int Shift = APoint + BPoint - OutPoint;

  if (Shift < 0 || OutWidth + Shift > AWidth + BWidth) begin : g_bad_qformat
    $error("mult_share_sched: result window falls outside the full product");
  end

  typedef struct packed {
    logic               valid;
    logic [IdWidth-1:0] id;
    logic [AWidth-1:0]  a;
    logic [BWidth-1:0]  b;
  } s1_t;

  typedef struct packed {
    logic                valid;
    logic [IdWidth-1:0]  id;
    logic [OutWidth-1:0] m;
  } s2_t;

  s1_t                 s1_q, s1_d;
  s2_t                 s2_q, s2_d;
  logic [IdWidth-1:0]  last_q, last_d;
  logic                adv1, adv2;
  logic                grant_any;
  logic [NReq-1:0]     grant_oh;
  logic [IdWidth-1:0]  grant_idx;
  logic [OutWidth-1:0] prod_m;

  rr_arbiter #(.N(NReq), .W(IdWidth)) u_arb (
    .req_i          (req_valid_i),
    .last_i         (last_q),
    .grant_onehot_o (grant_oh),
    .grant_idx_o    (grant_idx),
    .any_o          (grant_any)
  );

  multiplier #(
    .AWidth   (AWidth),
    .BWidth   (BWidth),
    .OutWidth (OutWidth),
    .Shift    (Shift)
  ) u_mul (
    .a_i (s1_q.a),
    .b_i (s1_q.b),
    .m_o (prod_m)
  );

  assign adv2 = !s2_q.valid || res_ready_i;
  assign adv1 = !s1_q.valid || adv2;

  // Ready is withheld during reset so nothing can be accepted into a clearing pipe.
  assign req_ready_o = (rst_n_i && adv1) ? grant_oh : '0;

  always_comb begin
    s1_d   = s1_q;
    s2_d   = s2_q;
    last_d = last_q;
    if (adv2) begin
      s2_d.valid = s1_q.valid;
      if (s1_q.valid) begin
        s2_d.id = s1_q.id;
        s2_d.m  = prod_m;
      end
    end
    if (adv1) begin
      s1_d.valid = grant_any;
      if (grant_any) begin
        s1_d.id = grant_idx;
        s1_d.a  = req_a_i[grant_idx*AWidth +: AWidth];
        s1_d.b  = req_b_i[grant_idx*BWidth +: BWidth];
        last_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q   <= '0;
      s2_q   <= '0;
      last_q <= IdWidth'(NReq - 1);
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      last_q <= last_d;
    end
  end

  assign res_valid_o = s2_q.valid;
  assign res_m_o     = s2_q.m;
  assign res_id_o    = s2_q.id;
  assign busy_o      = s1_q.valid || s2_q.valid;

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed and randomized checks of mult_share_sched against a behavioural model.
module tb_mult_share_sched;

  localparam int N = 3;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b1;
  logic [N-1:0]  req_valid_i = '0;
  logic [N-1:0]  req_ready_o;
  logic [47:0]   req_a_i = '0;
  logic [47:0]   req_b_i = '0;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic [15:0]   res_m_o;
  logic [1:0]    res_id_o;
  logic          busy_o;

  mult_share_sched dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_m_o     (res_m_o),
    .res_id_o    (res_id_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model: two in-flight slots (operand slot, result slot), RR pointer, result scoreboard.
  bit          mv1, mv2;
  logic [15:0] ma1, mb1, mm2;
  int          mid1, mid2;
  int          ptr;
  bit          last_acc;
  int          last_g;
  bit          refill;
  logic [15:0] sbm[$];
  int          sbid[$];
  logic [15:0] logm[$];
  int          logid[$];

  function automatic logic [15:0] prod(logic [15:0] a, logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 16'(p >>> 10);
  endfunction

  function automatic logic [63:0] log_m_at(int i);
    if (i < logm.size()) return 64'(logm[i]);
    return 'x;
  endfunction

  function automatic logic [63:0] log_id_at(int i);
    if (i < logid.size()) return 64'(logid[i]);
    return 'x;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mv1 = 0; mv2 = 0; ptr = N - 1;
    sbm.delete(); sbid.delete();
  endtask

  task automatic set_op(int k, logic [15:0] a, logic [15:0] b);
    req_a_i[k*16 +: 16] = a;
    req_b_i[k*16 +: 16] = b;
    req_valid_i[k] = 1'b1;
  endtask

  task automatic tick();
    int g;
    bit any, adv1, adv2;
    logic [2:0] exp_rdy;
    @(negedge clk_i);
    any = 0; g = 0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (!any && req_valid_i[idx]) begin any = 1; g = idx; end
    end
    adv2 = !mv2 || res_ready_i;
    adv1 = !mv1 || adv2;
    exp_rdy = (any && adv1) ? 3'(1 << g) : 3'b000;
    chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    chk("res_valid", 64'(res_valid_o), 64'(mv2));
    chk("busy", 64'(busy_o), 64'(mv1 | mv2));
    if (mv2) begin
      chk("res_m", 64'(res_m_o), 64'(mm2));
      chk("res_id", 64'(res_id_o), 64'(mid2));
    end
    if (res_valid_o && res_ready_i) begin
      logm.push_back(res_m_o);
      logid.push_back(int'(res_id_o));
      chk("sb_nonempty", 64'(sbm.size() > 0), 64'(1));
      if (sbm.size() > 0) begin
        chk("sb_m", 64'(res_m_o), 64'(sbm.pop_front()));
        chk("sb_id", 64'(res_id_o), 64'(sbid.pop_front()));
      end
    end
    last_acc = any && adv1;
    last_g = g;
    if (adv2 && mv1) begin mm2 = prod(ma1, mb1); mid2 = mid1; end
    if (adv2) mv2 = mv1;
    if (adv1) begin
      mv1 = last_acc;
      if (last_acc) begin
        ma1 = req_a_i[g*16 +: 16];
        mb1 = req_b_i[g*16 +: 16];
        mid1 = g;
        ptr = g;
        sbm.push_back(prod(ma1, mb1));
        sbid.push_back(g);
      end
    end
    @(posedge clk_i);
    #1;
    if (last_acc) begin
      if (refill) set_op(g, 16'($urandom), 16'($urandom));
      else req_valid_i[g] = 1'b0;
    end
  endtask

  initial begin
    int acc, nt;
    model_reset();
    refill = 0;

    // Reset state, with a request pending to confirm ready stays low in reset.
    #1 rst_n_i = 1'b0;
    req_valid_i = 3'b001;
    #2;
    chk("rst_res_valid", 64'(res_valid_o), 64'(0));
    chk("rst_res_m", 64'(res_m_o), 64'(0));
    chk("rst_res_id", 64'(res_id_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_req_ready", 64'(req_ready_o), 64'(0));
    req_valid_i = '0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    res_ready_i = 1'b1;

    // 1.5 * 2.0 from requester 0
    logm.delete(); logid.delete();
    set_op(0, 16'h0600, 16'h0800);
    repeat (4) tick();
    chk("t1_m", log_m_at(0), 64'h0C00);
    chk("t1_id", log_id_at(0), 64'd0);
    chk("t1_busy", 64'(busy_o), 64'(0));

    // Signed product and truncation toward -inf from requester 1
    logm.delete(); logid.delete();
    set_op(1, 16'hFA00, 16'h0800);
    repeat (3) tick();
    set_op(1, 16'h0001, 16'hFFFF);
    repeat (4) tick();
    chk("t2_m0", log_m_at(0), 64'hF400);
    chk("t2_id0", log_id_at(0), 64'd1);
    chk("t2_m1", log_m_at(1), 64'hFFFF);
    chk("t2_id1", log_id_at(1), 64'd1);

    // Fairness after idle: req2 alone, then req0 and req2 together
    set_op(2, 16'h0400, 16'h0400);
    repeat (4) tick();
    set_op(0, 16'h0200, 16'h0C00);
    set_op(2, 16'hFC00, 16'h0200);
    #1 chk("t5_first", 64'(req_ready_o), 64'b001);
    tick();
    #1 chk("t5_second", 64'(req_ready_o), 64'b100);
    repeat (4) tick();

    // All three valid continuously for nine accepts
    logm.delete(); logid.delete();
    refill = 1;
    for (int k = 0; k < N; k++) set_op(k, 16'($urandom), 16'($urandom));
    acc = 0; nt = 0;
    while (acc < 9 && nt < 20) begin
      tick();
      nt++;
      if (last_acc) acc++;
    end
    refill = 0;
    req_valid_i = '0;
    repeat (3) tick();
    chk("t3_accepts", 64'(acc), 64'(9));
    chk("t3_cycles", 64'(nt), 64'(9));
    for (int i = 0; i < 9; i++) chk("t3_id_seq", log_id_at(i), 64'(i % 3));

    // Backpressure: requester 2 streams while downstream stalls for five cycles
    logm.delete(); logid.delete();
    refill = 1;
    res_ready_i = 1'b0;
    set_op(2, 16'h0A00, 16'h0300);
    acc = 0;
    repeat (5) begin
      tick();
      if (last_acc) acc++;
    end
    chk("t4_accepts", 64'(acc), 64'(2));
    chk("t4_ready_low", 64'(req_ready_o), 64'(0));
    refill = 0;
    res_ready_i = 1'b1;
    repeat (6) begin
      tick();
      if (last_acc) acc++;
    end
    chk("t4_delivered", 64'(logm.size()), 64'(acc));

    // Reset with both stages full
    res_ready_i = 1'b0;
    set_op(0, 16'h0100, 16'h0100);
    tick();
    set_op(1, 16'h0200, 16'h0200);
    tick();
    #3 rst_n_i = 1'b0;
    #1;
    chk("t6_res_valid", 64'(res_valid_o), 64'(0));
    chk("t6_res_m", 64'(res_m_o), 64'(0));
    chk("t6_busy", 64'(busy_o), 64'(0));
    chk("t6_req_ready", 64'(req_ready_o), 64'(0));
    model_reset();
    req_valid_i = 3'b011;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    res_ready_i = 1'b1;
    #1 chk("t6_first_grant", 64'(req_ready_o), 64'b001);
    repeat (6) tick();

    // Randomized traffic with random downstream stalls
    for (int c = 0; c < 400; c++) begin
      res_ready_i = ($urandom % 4) != 0;
      for (int k = 0; k < N; k++) begin
        if (!req_valid_i[k] && ($urandom % 3) == 0) begin
          case ($urandom % 4)
            0: set_op(k, 16'h8000, 16'($urandom));
            1: set_op(k, 16'($urandom), 16'h7FFF);
            default: set_op(k, 16'($urandom), 16'($urandom));
          endcase
        end
      end
      tick();
    end
    req_valid_i = '0;
    res_ready_i = 1'b1;
    repeat (4) tick();
    chk("final_sb_empty", 64'(sbm.size()), 64'(0));
    chk("final_idle", 64'(busy_o), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_sched.md
Name: mult_share_sched

Overview:
- Time-shares one fixed-point multiplier between NReq requesters, e.g. the DWT lifting-step scaling units (alpha/beta/gamma/delta/K).
- Round-robin arbitration on a valid/ready request interface.
- Two-stage pipeline around a combinational signed multiply/truncate core.
- Single result stream tagged with the requester id, with backpressure.

Parameters:
- NReq, 3, number of requesters (≥2).
- AWidth, 16, operand A width, signed.
- APoint, 10, A fractional bits.
- BWidth, 16, operand B width, signed.
- BPoint, 10, B fractional bits.
- OutWidth, 16, result width, signed.
- OutPoint, 10, result fractional bits.
- IdWidth, $clog2(NReq), tag width.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  NReq  per-requester operand valid.
- req_ready_o  out  NReq  per-requester accept; at most one bit high (onehot0).
- req_a_i  in  NReq*AWidth  packed operand A; requester k at [k*AWidth +: AWidth].
- req_b_i  in  NReq*BWidth  packed operand B; same packing.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  downstream accept.
- res_m_o  out  OutWidth  signed product in Q(OutWidth-OutPoint).OutPoint.
- res_id_o  out  IdWidth  index of the requester that issued the operands.
- busy_o  out  1  high while any pipeline stage holds valid data.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - s1_valid=0, s2_valid=0, res_valid_o=0, res_m_o=0, res_id_o=0, busy_o=0, req_ready_o=0.
  - RR pointer last_grant=NReq-1, so requester 0 has first priority.
- Arithmetic:
  - Full product p = A*B, signed, AWidth+BWidth bits.
  - res_m_o = p[OutWidth+L-1 : L], where L = APoint+BPoint-OutPoint.
  - Truncation toward -inf; no rounding, no saturation; overflow wraps.
  - Parameters must satisfy L ≥ 0 and OutWidth+L ≤ AWidth+BWidth. Elaboration-time assertion otherwise.
- Pipeline:
  - S1 registers selected operands plus id.
  - S2 registers the truncated product plus id; S2 drives res_*.
  - Advance conditions:
    - adv2 = !s2_valid | res_ready_i
    - adv1 = !s1_valid | adv2
  - S1→S2 transfer when s1_valid & adv2.
  - S2 clears when res_ready_i & s2_valid and nothing enters.
- Arbitration (combinational):
  - Search req_valid_i starting at (last_grant+1) mod NReq, wrapping.
  - First asserted index g wins.
  - req_ready_o[g] = adv1; all other bits 0.
  - Handshake on req_valid_i[g] & req_ready_o[g]: load S1 with a[g], b[g], id=g; last_grant<=g.
  - No request: S1 loads s1_valid=0 when adv1; last_grant unchanged.
- req_ready_o may depend on req_valid_i. Requesters must hold valid and operands stable until accepted, and must not gate valid on ready.
- Latency: accepted at edge n → res_valid_o high after edge n+1 when not stalled.
- Throughput: 1 result/cycle with res_ready_i=1.
- Fairness: with all NReq valid continuously, grants are 0,1,…,NReq-1,0,…; no requester waits more than NReq-1 accepts.
- Backpressure:
  - res_ready_i=0 holds S2 stable (res_m_o, res_id_o, res_valid_o unchanged).
  - S1 may still fill once.
  - Then all req_ready_o=0 until res_ready_i returns.
  - Nothing is dropped or duplicated.
- Simultaneous events: S2 draining and S1 advancing in the same cycle is a full-rate transfer; a new grant is allowed in that cycle.
- busy_o = s1_valid | s2_valid.
- Reset mid-operation: in-flight results are discarded, no res_valid_o afterwards, pointer back to reset value.

Decomposition:
- Package mult_share_pkg:
  - id width function clog2_min1 (returns 1 when NReq=1).
  - Default Q-format localparams (Q6.10).
  - typedef of the S1/S2 stage struct {valid, id, a, b / m}.
- Sub-module rr_arbiter: parameter N; ports req_i[N], last_i, grant_onehot_o, grant_idx_o, any_o; purely combinational.
- Multiply/truncate is the team's existing Multiplier core, instantiated between S1 and S2.

Test Plan:
1. Single req0, a=0x0600 (1.5), b=0x0800 (2.0), res_ready_i=1 → two cycles later res_valid_o=1, res_m_o=0x0C00, res_id_o=0, busy_o low afterwards.
2. Signed product: req1, a=0xFA00 (-1.5), b=0x0800 → res_m_o=0xF400, id=1. Also a=0x0001, b=0xFFFF → 0xFFFF (truncation toward -inf).
3. All three valid continuously for 9 accepts, ready=1 → res_id_o sequence 0,1,2,0,1,2,0,1,2 on consecutive cycles, no bubbles.
4. Backpressure: stream from req2, res_ready_i=0 for 5 cycles → exactly 2 accepts, then req_ready_o=0; res_m_o stable. On release, results emerge in order without loss or duplication.
5. Fairness after idle: req2 alone once, then req0 and req2 together → req0 granted first (pointer at 2), then req2.
6. Reset mid-stream: assert rst_n_i low with both stages valid → outputs 0 immediately (async). After release, first grant goes to req0 and no stale result appears.
